// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 16-bit datapath ALU feeding the processor status register.
// Arithmetic and logic ops finish in one cycle. Shifts iterate one bit per cycle.
// MUL iterates as shift-add over WIDTH cycles. Result, CLFZN and the Set strobes
// are registered and are presented together in the single FIN (done) cycle.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       CLFZN,
  output logic             SetC,
  output logic             SetL,
  output logic             SetF,
  output logic             SetZ,
  output logic             SetN
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_ASHR = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  // Flag bit positions inside CLFZN and the strobe vector
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic             dir_reg;      // LSH direction: 1 = right
  logic [WIDTH-1:0] acc_reg;      // shift value, or MUL partial product
  logic [WIDTH-1:0] mcand_reg;    // MUL multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_reg;   // MUL multiplier, shifted right each step
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic [4:0]       flags_reg;
  logic [4:0]       set_reg;

  logic [WIDTH-1:0] quick_result;
  logic [4:0]       quick_flags;
  logic [4:0]       quick_set;
  logic             go_run;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ci;
  logic             sub_bi;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mcand_step;
  logic [WIDTH-1:0] mplier_step;

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == FIN);
  assign result = result_reg;
  assign CLFZN  = flags_reg;
  assign SetC   = set_reg[FC];
  assign SetL   = set_reg[FL];
  assign SetF   = set_reg[FF];
  assign SetZ   = set_reg[FZ];
  assign SetN   = set_reg[FN];

  // Single-cycle evaluation straight from the inputs at the start edge
  always_comb begin
    quick_result = '0;
    quick_flags  = '0;
    quick_set    = '0;
    add_ci       = (op == OP_ADDC) ? cin : 1'b0;
    sub_bi       = (op == OP_SUBC) ? cin : 1'b0;
    sum_ext      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_ci};
    diff_ext     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bi};
    go_run       = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        quick_result    = sum_ext[WIDTH-1:0];
        quick_set[FC]   = 1'b1;
        quick_set[FF]   = 1'b1;
        quick_flags[FC] = sum_ext[WIDTH];
        quick_flags[FF] = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SUBC: begin
        quick_result    = diff_ext[WIDTH-1:0];
        quick_set[FC]   = 1'b1;
        quick_set[FF]   = 1'b1;
        quick_flags[FC] = diff_ext[WIDTH];
        quick_flags[FF] = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        quick_result    = a;
        quick_set[FL]   = 1'b1;
        quick_set[FZ]   = 1'b1;
        quick_set[FN]   = 1'b1;
        quick_flags[FL] = (a < b);
        quick_flags[FZ] = (a == b);
        quick_flags[FN] = ($signed(a) < $signed(b));
      end
      OP_AND: quick_result = a & b;
      OP_OR:  quick_result = a | b;
      OP_XOR: quick_result = a ^ b;
      OP_MOV: quick_result = b;
      OP_LSH, OP_ASHR: begin
        // a zero shift count completes immediately with the operand unchanged
        quick_result = a;
        go_run       = (b[3:0] != 4'd0);
      end
      OP_MUL: go_run = 1'b1;
      default: quick_result = '0;
    endcase
  end

  // One iteration of the running shift or shift-add multiply
  always_comb begin
    acc_step    = acc_reg;
    mcand_step  = mcand_reg;
    mplier_step = mplier_reg;
    case (op_reg)
      OP_LSH:  acc_step = dir_reg ? {1'b0, acc_reg[WIDTH-1:1]} : {acc_reg[WIDTH-2:0], 1'b0};
      OP_ASHR: acc_step = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
      OP_MUL: begin
        acc_step    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_step  = {mcand_reg[WIDTH-2:0], 1'b0};
        mplier_step = {1'b0, mplier_reg[WIDTH-1:1]};
      end
      default: acc_step = acc_reg;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; FIN always returns to IDLE so a start there is dropped
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = go_run ? RUN : FIN;
      RUN:  if (cnt_reg == CW'(1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and loading of the done-cycle outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= '0;
      dir_reg    <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      set_reg    <= '0;
    end else begin
      // flags and strobes live for exactly the FIN cycle
      flags_reg <= '0;
      set_reg   <= '0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg  <= op;
            dir_reg <= b[4];
            if (go_run) begin
              acc_reg    <= (op == OP_MUL) ? '0 : a;
              mcand_reg  <= a;
              mplier_reg <= b;
              cnt_reg    <= (op == OP_MUL) ? CW'(WIDTH) : CW'(b[3:0]);
            end else begin
              result_reg <= quick_result;
              flags_reg  <= quick_flags & quick_set;
              set_reg    <= quick_set;
            end
          end
        end
        RUN: begin
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_step;
          mplier_reg <= mplier_step;
          cnt_reg    <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) result_reg <= acc_step;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results, flags and latencies.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [4:0]  CLFZN;
  logic        SetC, SetL, SetF, SetZ, SetN;

  int tests_run = 0;
  int tests_failed = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .CLFZN(CLFZN),
    .SetC(SetC), .SetL(SetL), .SetF(SetF), .SetZ(SetZ), .SetN(SetN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {SetC, SetL, SetF, SetZ, SetN};
  endfunction

  // Issue one op, wait (bounded) for done, check latency/result/flags/strobes
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci, input int exp_lat,
                        input logic [15:0] exp_r, input logic [4:0] exp_set,
                        input logic [4:0] exp_f);
    int lat;
    logic seen;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; cin = ci;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = ~ci;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_set"}, 32'(strobes()), 32'(exp_set));
    check({tag, "_clfzn"}, 32'(CLFZN), 32'(exp_f));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    $display("[TB] %s op=%0d a=%h b=%h cin=%0d lat=%0d result=%h set=%b clfzn=%b",
             tag, o, av, bv, ci, lat, result, strobes(), CLFZN);
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_set_clr"}, 32'(strobes()), 32'd0);
  endtask

  initial begin
    int ndone;
    int done_lat;
    logic [15:0] done_res;
    logic [4:0]  done_set;

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_clfzn", 32'(CLFZN), 32'd0);
    check("rst_set", 32'(strobes()), 32'd0);
    $display("[TB] reset state observed");
    reset = 1'b1;

    //        tag        op     a         b         cin  lat  result    set       CLFZN
    run_op("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 5'b10100, 5'b00100);
    run_op("add_carry",4'd0,  16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 5'b10100, 5'b10000);
    run_op("add_nocin",4'd0,  16'h0001, 16'h0001, 1'b1, 1, 16'h0002, 5'b10100, 5'b00000);
    run_op("sub_brw",  4'd2,  16'h0003, 16'h0005, 1'b0, 1, 16'hFFFE, 5'b10100, 5'b10000);
    run_op("addc",     4'd1,  16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 5'b10100, 5'b00000);
    run_op("subc_ovf", 4'd3,  16'h8000, 16'h0001, 1'b1, 1, 16'h7FFE, 5'b10100, 5'b00100);
    run_op("cmp_neg",  4'd4,  16'hFFFF, 16'h0001, 1'b0, 1, 16'hFFFF, 5'b01011, 5'b00001);
    run_op("cmp_eq",   4'd4,  16'h1234, 16'h1234, 1'b0, 1, 16'h1234, 5'b01011, 5'b00010);
    run_op("cmp_lt",   4'd4,  16'h0001, 16'h8000, 1'b0, 1, 16'h0001, 5'b01011, 5'b01000);
    run_op("and",      4'd5,  16'hF0F0, 16'hFF00, 1'b0, 1, 16'hF000, 5'b00000, 5'b00000);
    run_op("or",       4'd6,  16'hF0F0, 16'hFF00, 1'b0, 1, 16'hFFF0, 5'b00000, 5'b00000);
    run_op("xor",      4'd7,  16'hF0F0, 16'hFF00, 1'b0, 1, 16'h0FF0, 5'b00000, 5'b00000);
    run_op("mov",      4'd8,  16'hF0F0, 16'hFF00, 1'b0, 1, 16'hFF00, 5'b00000, 5'b00000);
    run_op("illegal",  4'd13, 16'h1111, 16'h2222, 1'b1, 1, 16'h0000, 5'b00000, 5'b00000);
    run_op("lsh_l15",  4'd9,  16'h0001, 16'h000F, 1'b0, 16, 16'h8000, 5'b00000, 5'b00000);
    run_op("lsh_n0",   4'd9,  16'hABCD, 16'h0010, 1'b0, 1, 16'hABCD, 5'b00000, 5'b00000);
    run_op("lsh_r3",   4'd9,  16'h8000, 16'h0013, 1'b0, 4, 16'h1000, 5'b00000, 5'b00000);
    run_op("ashr_neg", 4'd10, 16'h8000, 16'h0004, 1'b0, 5, 16'hF800, 5'b00000, 5'b00000);
    run_op("ashr_pos", 4'd10, 16'h4000, 16'h0002, 1'b0, 3, 16'h1000, 5'b00000, 5'b00000);
    run_op("mul_a",    4'd11, 16'h00FF, 16'h0101, 1'b0, 17, 16'hFFFF, 5'b00000, 5'b00000);
    run_op("mul_wrap", 4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 17, 16'h0001, 5'b00000, 5'b00000);

    // MUL with a stray ADD start while busy: exactly one done, MUL result
    @(negedge clk);
    start = 1'b1; op = 4'd11; a = 16'h0123; b = 16'h0010; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; done_lat = 0; done_res = '0; done_set = '0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        done_lat = cyc;
        done_res = result;
        done_set = strobes();
      end
    end
    start = 1'b0;
    check("mul_ign_ndone", 32'(ndone), 32'd1);
    check("mul_ign_lat", 32'(done_lat), 32'd17);
    check("mul_ign_result", 32'(done_res), 32'h1230);
    check("mul_ign_set", 32'(done_set), 32'd0);
    $display("[TB] mul_ign dones=%0d lat=%0d result=%h", ndone, done_lat, done_res);

    // Abort a MUL with reset mid-run
    @(negedge clk);
    start = 1'b1; op = 4'd11; a = 16'h0003; b = 16'h0005;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_set", 32'(strobes()), 32'd0);
    check("abort_clfzn", 32'(CLFZN), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", 32'(ndone), 32'd0);
    $display("[TB] abort dones_after_release=%0d", ndone);
    run_op("add_after", 4'd0, 16'h0002, 16'h0003, 1'b0, 1, 16'h0005, 5'b10100, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
